// File: rtl/fp4_fft_pkg.sv
// rtl/fp4_fft_pkg.sv - shared constants, sample type, loader states and bit reversal for the FP4 FFT
package fp4_fft_pkg;

  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [3:0] re;
    logic [3:0] im;
  } fp4_cplx_t;

  typedef enum logic {
    ST_FILL      = 1'b0,
    ST_WAIT_SWAP = 1'b1
  } loader_state_t;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = addr[ADDR_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fp4_addr_bitrev.sv
// rtl/fp4_addr_bitrev.sv - sample-count to memory-address map
// FP4_LOADER_BITREV_EN selects bit-reversed (DIT) order; otherwise natural order.
module fp4_addr_bitrev #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] cnt,
  output logic [ADDR_W-1:0] addr
);

`ifdef FP4_LOADER_BITREV_EN
  always_comb begin
    addr = '0;
    for (int i = 0; i < ADDR_W; i++) addr[i] = cnt[ADDR_W-1-i];
  end
`else
  assign addr = cnt;
`endif

endmodule

// File: rtl/fp4_fft_input_loader.sv
// rtl/fp4_fft_input_loader.sv - streams FP4 frames into the filling bank and hands them to the FFT core
// Address order set by FP4_LOADER_BITREV_EN (see fp4_addr_bitrev).
module fp4_fft_input_loader
  import fp4_fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr_1,
  output logic [DATA_W-1:0] wr_data_1,
  output logic              bank_sel,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              frame_err
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  fp4_cplx_t         wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              bank_sel_q, bank_sel_d;
  logic              fft_start_q, fft_start_d;
  logic              frame_err_q, frame_err_d;
  logic              core_busy_q, core_busy_d;
  logic [ADDR_W-1:0] addr_map;
  logic              hs;
  logic              cnt_last;

  fp4_addr_bitrev #(.ADDR_W(ADDR_W)) u_addr_map (
    .cnt  (cnt_q),
    .addr (addr_map)
  );

  assign in_ready  = rst & (state_q == ST_FILL);
  assign hs        = in_valid & in_ready;
  assign cnt_last  = (cnt_q == ADDR_W'(N-1));

  assign wr_en_1   = wr_en_q;
  assign wr_addr_1 = wr_addr_q;
  assign wr_data_1 = wr_data_q;
  assign bank_sel  = bank_sel_q;
  assign fft_start = fft_start_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_sel_d  = bank_sel_q;
    fft_start_d = 1'b0;
    frame_err_d = frame_err_q;
    core_busy_d = core_busy_q;
    if (fft_done) core_busy_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_map;
          wr_data_d = in_data;
          cnt_d     = cnt_q + 1'b1;
          // frame closes on count; in_last only flags misalignment
          if (in_last != cnt_last) frame_err_d = 1'b1;
          if (cnt_last) state_d = ST_WAIT_SWAP;
        end
      end
      ST_WAIT_SWAP: begin
        if (!core_busy_q) begin
          bank_sel_d  = ~bank_sel_q;
          core_busy_d = 1'b1;
          fft_start_d = 1'b1;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bank_sel_q  <= 1'b0;
      fft_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      core_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      bank_sel_q  <= bank_sel_d;
      fft_start_q <= fft_start_d;
      frame_err_q <= frame_err_d;
      core_busy_q <= core_busy_d;
    end
  end

endmodule

// File: tb/tb_fp4_fft_input_loader.sv
// tb/tb_fp4_fft_input_loader.sv - scoreboard bench for fp4_fft_input_loader
// Expected address order follows FP4_LOADER_BITREV_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_fp4_fft_input_loader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          fft_done = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en_1, bank_sel, fft_start, frame_err;
  logic [AW-1:0] wr_addr_1;
  logic [DW-1:0] wr_data_1;

  always #5 clk = ~clk;

  fp4_fft_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .wr_en_1   (wr_en_1),
    .wr_addr_1 (wr_addr_1),
    .wr_data_1 (wr_data_1),
    .bank_sel  (bank_sel),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .frame_err (frame_err)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t  exp_q[$];
  int   mem[2][N];
  int   checks = 0;
  int   passed = 0;
  int   start_cnt = 0;
  logic exp_bank = 1'b0;
  logic exp_err = 1'b0;

  function automatic int exp_addr(input int k);
`ifdef FP4_LOADER_BITREV_EN
    int r = 0;
    int v = k;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // monitor: pops the scoreboard on every write-port cycle and mirrors the memory
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (fft_start === 1'b1) start_cnt++;
      if (wr_en_1 === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", int'(wr_addr_1), e.addr);
          check("wr_data", int'(wr_data_1), e.data);
        end
        mem[bank_sel ? 0 : 1][wr_addr_1] = int'(wr_data_1);
      end
    end
  end

  task automatic send_frame(input int nsamp, input int pct, input int last_pos, input bit rnd);
    int k = 0;
    int cyc = 0;
    while (k < nsamp && cyc < 3000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) < pct);
      in_data  = rnd ? DW'($urandom) : DW'(k);
      in_last  = (k == last_pos);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back('{exp_addr(k), int'(in_data)});
        if ((k == last_pos) != (k == N-1)) exp_err = 1'b1;
        k++;
      end
      cyc++;
    end
    if (k < nsamp) check("frame_timeout", k, nsamp);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  task automatic idle_swap();
    check("wait_swap_ready", int'(in_ready), 0);
    check("pre_swap_bank", int'(bank_sel), int'(exp_bank));
    @(negedge clk); #1;
    exp_bank = ~exp_bank;
    check("swap_bank", int'(bank_sel), int'(exp_bank));
    check("start_pulse", int'(fft_start), 1);
    check("refill_ready", int'(in_ready), 1);
    @(negedge clk); #1;
    check("start_one_cycle", int'(fft_start), 0);
  endtask

  task automatic busy_swap();
    check("busy_hold_ready", int'(in_ready), 0);
    repeat (4) begin
      @(negedge clk); #1;
      check("busy_hold_ready", int'(in_ready), 0);
      check("busy_hold_bank", int'(bank_sel), int'(exp_bank));
      check("busy_no_start", int'(fft_start), 0);
    end
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    #1;
    check("done_edge_bank", int'(bank_sel), int'(exp_bank));
    check("done_edge_start", int'(fft_start), 0);
    @(negedge clk); #1;
    exp_bank = ~exp_bank;
    check("busy_swap_bank", int'(bank_sel), int'(exp_bank));
    check("busy_swap_start", int'(fft_start), 1);
    check("busy_refill_ready", int'(in_ready), 1);
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_wr_en", int'(wr_en_1), 0);
    check("rst_wr_addr", int'(wr_addr_1), 0);
    check("rst_wr_data", int'(wr_data_1), 0);
    check("rst_bank_sel", int'(bank_sel), 0);
    check("rst_fft_start", int'(fft_start), 0);
    check("rst_frame_err", int'(frame_err), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_reset", int'(in_ready), 1);

    // frame 1: ramp data, back-to-back, core idle
    send_frame(N, 100, N-1, 1'b0);
    idle_swap();
    check("mem_sample1", mem[1][exp_addr(1)], 1);
    check("mem_sample3", mem[1][exp_addr(3)], 3);
    check("mem_sample31", mem[1][exp_addr(31)], 31);

    // frame 2: core stays busy until fft_done
    send_frame(N, 100, N-1, 1'b1);
    busy_swap();

    // frame 3: 50% valid
    pulse_done();
    send_frame(N, 50, N-1, 1'b1);
    idle_swap();
    check("no_frame_err", int'(frame_err), int'(exp_err));

    // frame 4: in_last on sample 10
    pulse_done();
    send_frame(N, 70, 10, 1'b1);
    check("frame_err_set", int'(frame_err), int'(exp_err));
    idle_swap();
    repeat (3) @(negedge clk);
    #1;
    check("frame_err_sticky", int'(frame_err), 1);

    // partial frame then mid-operation reset
    pulse_done();
    send_frame(12, 100, -1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    check("queue_drained", exp_q.size(), 0);
    exp_bank = 1'b0;
    exp_err  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;

    // frame 6: restarts at cnt 0 with idle core
    send_frame(N, 100, N-1, 1'b1);
    idle_swap();
    check("frame_err_clear", int'(frame_err), int'(exp_err));

    repeat (2) @(negedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("start_count", start_cnt, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp4_fft_input_loader.md
# fp4_fft_input_loader

Upstream stage of the FP4 FFT ping-pong memory. It accepts a valid/ready stream of packed FP4 complex samples and writes each 32-sample frame into the filling bank of `fp4_fft_memory_dff` in bit-reversed order. When a frame is complete and the FFT core is idle, it swaps banks and issues a one-cycle start to the core. It owns `bank_sel` for the memory and the core.

## Interface
- `N`, 32, samples per frame (power of two)
- `ADDR_W`, 5, log2(N), memory address width
- `DATA_W`, 8, sample width: [7:4] real FP4, [3:0] imag FP4
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  loader can accept a sample
- `in_data`  in  DATA_W  packed complex sample
- `in_last`  in  1  marks the final sample of a frame; alignment check only
- `wr_en_1`  out  1  memory write-port enable, one cycle per sample
- `wr_addr_1`  out  ADDR_W  memory write address
- `wr_data_1`  out  DATA_W  memory write data
- `bank_sel`  out  1  processing-bank select; the memory writes to `~bank_sel`
- `fft_start`  out  1  one-cycle pulse: a new frame is in the processing bank
- `fft_done`  in  1  one-cycle pulse from the core: frame processed
- `frame_err`  out  1  sticky flag for an `in_last` misalignment

## Operation
- States:
  - FILL: `in_ready=1`. Each handshake (`in_valid & in_ready` at a posedge) registers `wr_data_1=in_data`, `wr_addr_1=addr(cnt)`, `wr_en_1=1` for the next cycle, then increments `cnt` (ADDR_W bits).
  - FILL -> WAIT_SWAP on the handshake with `cnt==N-1`; `cnt` wraps to 0.
  - WAIT_SWAP: `in_ready=0`. At the first posedge with `core_busy==0`: toggle `bank_sel`, set `core_busy`, register `fft_start=1` for one cycle, go to FILL.
- `core_busy`:
  - Set on issuing `fft_start`.
  - Cleared on `fft_done`.
  - `fft_done` while not busy is ignored.
  - Start and done cannot coincide, because start is issued only when not busy.
- `in_last` check:
  - `in_last=1` on a handshake with `cnt!=N-1` sets `frame_err`.
  - `in_last=0` on the handshake with `cnt==N-1` also sets `frame_err`.
  - The frame always closes on count, never on `in_last`.
  - `frame_err` clears only on reset.
- A sample presented in WAIT_SWAP is not consumed; it stays pending until FILL resumes.
- Mid-operation reset: any partial frame is discarded and the bank contents are left as they are.

## Timing
- Reset values:
  - `in_ready=0` while `rst` is low; the state is FILL after release.
  - `wr_en_1=0`, `wr_addr_1=0`, `wr_data_1=0`, `bank_sel=0`, `fft_start=0`, `frame_err=0`, `cnt=0`, `core_busy=0`.
- Sample latency: handshake at edge E puts the sample on the write port in the cycle after E; the memory commits it at E+1.
- Last sample accepted at E0 gives the earliest swap at E1:
  - The last write commits at E1 using the pre-edge `bank_sel`, so it lands in the correct bank.
  - `fft_start` is high in the cycle after E1.
- Throughput: N samples per frame plus at least 1 bubble cycle (WAIT_SWAP) per frame.
- While the core is busy, WAIT_SWAP holds indefinitely.

## Configuration
- `FP4_LOADER_BITREV_EN`:
  - Defined: `addr(cnt)` is the ADDR_W-bit reversal of `cnt`, giving a DIT input ordering.
  - Undefined: `addr(cnt)=cnt`, natural order, for cores that reorder internally.

## Structure
- Shared package `fp4_fft_pkg` holds:
  - `N`, `ADDR_W`, `DATA_W` constants.
  - The packed complex sample typedef.
  - The loader state enum.
  - Function `bitrev(addr)`.
- Sub-module `fp4_addr_bitrev`: combinational, ADDR_W-parameterised, selected by the macro.

## Test plan
1. Reset, then stream 32 samples `k` (data=k), back-to-back with the core idle -> `wr_en_1` for 32 cycles:
   - With BITREV: sample 1 goes to addr 16, sample 3 to addr 24.
   - `bank_sel` becomes 1 on the edge after the last commit.
   - One `fft_start` pulse; the memory read at `bank_sel=1`, addr 16 returns 8'h01.
2. Hold `fft_done` low, stream a second frame -> after 32 samples, `in_ready=0` and `bank_sel` stays 1. Pulse `fft_done` -> swap to 0 the next edge and `fft_start` fires once.
3. Toggle `in_valid` randomly (50%) -> the addresses written are still the exact bit-reverse sequence and no sample is dropped or duplicated.
4. Assert `in_last` on sample 10 -> `frame_err=1` and stays set. The frame still closes after sample 31.
5. Deassert `rst` after 12 samples -> all outputs return to reset values. The next 32 samples start again at `cnt=0`.
6. Build without `FP4_LOADER_BITREV_EN` -> `wr_addr_1` follows 0,1,2,…,31.
